// File: rtl/seq_010_stimulus_gen.sv
// Serial frame generator for the 010 sequence detector: shifts host frames out MSB-first
// and keeps a golden count of overlapping 010 patterns in the exact waveform driven on x.
module seq_010_stimulus_gen #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned LEN_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] data,
   input  logic [LEN_W-1:0] len,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [31:0]      exp_count
);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);
   localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
   localparam logic [WIDTH-1:0] BIT0    = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] frame_q, frame_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [1:0]       hist_q, hist_d;
   logic [31:0]      cnt_q, cnt_d;

   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      idx_d     = idx_q;
      x_d       = x_q;
      x_valid_d = x_valid_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if ((len == '0) || (len > MAX_LEN)) begin
                  err_d = 1'b1;
               end else begin
                  frame_d   = data;
                  idx_d     = len - ONE;
                  x_d       = |(data & (BIT0 << idx_d));
                  x_valid_d = 1'b1;
                  busy_d    = 1'b1;
                  state_d   = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (idx_q != '0) begin
               idx_d = idx_q - ONE;
               x_d   = |(frame_q & (BIT0 << idx_d));
            end else begin
               // x keeps the last frame bit through the gap
               x_valid_d = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // history advances every edge, so idle hold cycles are part of the waveform seen
      hist_d = {hist_q[0], x_d};
      cnt_d  = ({hist_q, x_d} == 3'b010) ? cnt_q + 32'd1 : cnt_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         frame_q   <= '0;
         idx_q     <= '0;
         x_q       <= 1'b0;
         x_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         hist_q    <= 2'b11;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         idx_q     <= idx_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         hist_q    <= hist_d;
         cnt_q     <= cnt_d;
      end
   end

   assign x         = x_q;
   assign x_valid   = x_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign exp_count = cnt_q;

endmodule

// File: tb/tb_seq_010_stimulus_gen.sv
// Bench for seq_010_stimulus_gen: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based waveform model.
module tb_seq_010_stimulus_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] data;
   logic [4:0]  len;
   logic        x, x_valid, busy, done, err;
   logic [31:0] exp_count;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   seq_010_stimulus_gen #(.WIDTH(16), .LEN_W(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .data      (data),
      .len       (len),
      .x         (x),
      .x_valid   (x_valid),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .exp_count (exp_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Model: pending frame bits in a queue, the driven waveform in a list seeded with 1,1.
   logic        mq[$];
   logic        mw[$];
   logic        m_x, m_xv, m_busy, m_done, m_err;
   logic [31:0] m_cnt;

   task automatic model_reset();
      mq.delete();
      mw.delete();
      mw.push_back(1'b1);
      mw.push_back(1'b1);
      m_x = 1'b0; m_xv = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_cnt = '0;
   endtask

   task automatic model_edge(input logic s, input logic [15:0] d, input logic [4:0] l);
      int unsigned n;
      if (!reset) return;
      m_done = 1'b0;
      m_err  = 1'b0;
      if (!m_busy && s) begin
         if (l == 5'd0 || l > 5'd16) m_err = 1'b1;
         else for (int i = int'(l) - 1; i >= 0; i--) mq.push_back(d[i]);
      end
      if (mq.size() > 0) begin
         m_x = mq.pop_front();
         m_xv = 1'b1;
         m_busy = 1'b1;
      end else if (m_busy) begin
         m_xv = 1'b0;
         m_busy = 1'b0;
         m_done = 1'b1;
      end else begin
         m_xv = 1'b0;
      end
      mw.push_back(m_x);
      n = mw.size();
      if (mw[n-3] == 1'b0 && mw[n-2] == 1'b1 && mw[n-1] == 1'b0) m_cnt = m_cnt + 32'd1;
      if (n > 8) void'(mw.pop_front());
   endtask

   task automatic check(input string name, input logic [36:0] expv);
      logic [36:0] got;
      got = {x, x_valid, busy, done, err, exp_count};
      vectors++;
      if (got !== expv) begin
         miscompares++;
         $display("FAIL %s: got x=%b v=%b busy=%b done=%b err=%b cnt=%0d, want x=%b v=%b busy=%b done=%b err=%b cnt=%0d",
                  name, got[36], got[35], got[34], got[33], got[32], got[31:0],
                  expv[36], expv[35], expv[34], expv[33], expv[32], expv[31:0]);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] expv);
      vectors++;
      if (got !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", name, got, expv);
      end
   endtask

   task automatic step(input logic s, input logic [15:0] d, input logic [4:0] l);
      start = s; data = d; len = l;
      @(posedge clk);
      model_edge(s, d, l);
      #1;
      check("model", {m_x, m_xv, m_busy, m_done, m_err, m_cnt});
   endtask

   task automatic reset_pulse(input int unsigned cycles);
      reset = 1'b0;
      model_reset();
      #1;
      check("reset_now", {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
      for (int unsigned k = 0; k < cycles; k++) step(1'b0, 16'h0, 5'd0);
      reset = 1'b1;
   endtask

   typedef struct {
      logic        s;
      logic [15:0] d;
      logic [4:0]  l;
      logic        x, xv, bsy, dn, er;
      logic [31:0] cnt;
   } vec_t;

   vec_t tbl[14];

   initial begin
      logic [31:0] base;
      int unsigned dones;
      logic [5:0]  seen;
      logic        exp_x[4];

      // single frame 0101_1010, then two illegal lengths
      tbl[0]  = '{1'b1, 16'h005A, 5'd8,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0};
      tbl[1]  = '{1'b0, 16'h0000, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0};
      tbl[2]  = '{1'b0, 16'h0000, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1};
      tbl[3]  = '{1'b0, 16'h0000, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1};
      tbl[4]  = '{1'b0, 16'h0000, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1};
      tbl[5]  = '{1'b0, 16'h0000, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1};
      tbl[6]  = '{1'b0, 16'h0000, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1};
      tbl[7]  = '{1'b0, 16'h0000, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd2};
      tbl[8]  = '{1'b0, 16'h0000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2};
      tbl[9]  = '{1'b0, 16'h0000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2};
      tbl[10] = '{1'b1, 16'hFFFF, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2};
      tbl[11] = '{1'b0, 16'hFFFF, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2};
      tbl[12] = '{1'b1, 16'hFFFF, 5'd17, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2};
      tbl[13] = '{1'b0, 16'h0000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2};

      start = 1'b0; data = '0; len = '0;
      reset = 1'b0;
      model_reset();
      #12;
      check("reset_state", {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
      @(posedge clk); #1;
      reset = 1'b1;
      step(1'b0, 16'h0, 5'd0);
      step(1'b0, 16'h0, 5'd0);

      for (int unsigned i = 0; i < 14; i++) begin
         step(tbl[i].s, tbl[i].d, tbl[i].l);
         check($sformatf("tbl%0d", i),
               {tbl[i].x, tbl[i].xv, tbl[i].bsy, tbl[i].dn, tbl[i].er, tbl[i].cnt});
      end

      // overlapping 01010 counts twice
      base = m_cnt;
      step(1'b1, 16'b01010, 5'd5);
      step(1'b0, 16'h0, 5'd0);
      step(1'b0, 16'h0, 5'd0);
      check_val("ovl_bit3", exp_count, base + 32'd1);
      step(1'b0, 16'h0, 5'd0);
      step(1'b0, 16'h0, 5'd0);
      check_val("ovl_bit5", exp_count, base + 32'd2);
      step(1'b0, 16'h0, 5'd0);
      step(1'b0, 16'h0, 5'd0);
      step(1'b0, 16'h0, 5'd0);

      // held bit fills the gap between back-to-back frames
      base = m_cnt;
      exp_x = '{1'b0, 1'b1, 1'b1, 1'b0};
      step(1'b1, 16'b01, 5'd2);
      check_val("gap_x0", {31'd0, x}, {31'd0, exp_x[0]});
      step(1'b0, 16'h0, 5'd0);
      check_val("gap_x1", {31'd0, x}, {31'd0, exp_x[1]});
      step(1'b0, 16'h0, 5'd0);
      check_val("gap_done_x", {30'd0, done, x}, {30'd0, 1'b1, exp_x[2]});
      step(1'b1, 16'b0, 5'd1);
      check_val("gap_x3", {30'd0, x_valid, x}, {30'd0, 1'b1, exp_x[3]});
      step(1'b0, 16'h0, 5'd0);
      check_val("gap_cnt", exp_count, base);
      step(1'b0, 16'h0, 5'd0);

      // start while busy is ignored
      dones = 0;
      seen = '0;
      step(1'b1, 16'b101100, 5'd6);
      seen = {seen[4:0], x};
      for (int unsigned k = 0; k < 9; k++) begin
         step((k == 1 || k == 2) ? 1'b1 : 1'b0, 16'hFFFF, 5'd6);
         if (x_valid) seen = {seen[4:0], x};
         if (done) dones++;
      end
      check_val("busy_frame", {26'd0, seen}, {26'd0, 6'b101100});
      check_val("busy_dones", dones, 32'd1);

      // reset on the third bit of a long frame
      step(1'b1, 16'b1011010011, 5'd10);
      step(1'b0, 16'h0, 5'd0);
      step(1'b0, 16'h0, 5'd0);
      reset_pulse(3);
      dones = 0;
      step(1'b0, 16'h0, 5'd0);
      if (done) dones++;
      step(1'b0, 16'h0, 5'd0);
      if (done) dones++;
      step(1'b1, 16'b010, 5'd3);
      if (done) dones++;
      check_val("rst_no_done", dones, 32'd0);
      step(1'b0, 16'h0, 5'd0);
      step(1'b0, 16'h0, 5'd0);
      step(1'b0, 16'h0, 5'd0);
      check_val("rst_after_cnt", exp_count, 32'd1);

      // randomized traffic
      for (int unsigned i = 0; i < 1500; i++) begin
         logic [4:0] l;
         if ($urandom_range(0, 199) == 0) begin
            reset_pulse($urandom_range(1, 2));
         end else begin
            l = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 16));
            step($urandom_range(0, 2) == 0, 16'($urandom), l);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seq_010_stimulus_gen.md
# seq_010_stimulus_gen

Serial bit-stream generator that drives the `x` input of the `010` sequence detector. It shifts out host-supplied frames MSB-first and keeps a golden count of overlapping `010` occurrences in the exact waveform it drives. A bench or upstream block compares that count against the detector's `count`. It sits at the transmit end of the detector's serial input.

## Interface
- `WIDTH`, default 16: maximum frame length in bits.
- `LEN_W`, default 5: width of `len`. Must satisfy 2^LEN_W > WIDTH.
- `clk`, input, 1: single clock. All state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-low. Clears all state immediately.
- `start`, input, 1: frame request. Sampled only when `busy`=0.
- `data`, input, WIDTH: frame bits, right-justified. Bit `len-1` is sent first.
- `len`, input, LEN_W: frame length in bits. Legal range is 1..WIDTH.
- `x`, output, 1: serial bit stream to the detector.
- `x_valid`, output, 1: high while `x` carries a frame bit.
- `busy`, output, 1: high while a frame is shifting.
- `done`, output, 1: single-cycle pulse after the last frame bit.
- `err`, output, 1: single-cycle pulse when `start` is rejected for an illegal `len`.
- `exp_count`, output, 32: golden count of `010` patterns in `x` since reset.

## Operation
- Reset values: `x`=0, `x_valid`=0, `busy`=0, `done`=0, `err`=0, `exp_count`=0, internal history `hist`=2'b11, state=IDLE.
- States: IDLE and SHIFT.
- IDLE, `start`=1, legal `len`:
  - Latch `data` and `len`; bit index = `len-1`.
  - Launch `x`=`data[len-1]`, `x_valid`=1, `busy`=1; go to SHIFT.
- IDLE, `start`=1, `len`=0 or `len`>WIDTH: pulse `err`, stay in IDLE, nothing latched.
- SHIFT, index>0: decrement index; launch the next lower bit.
- SHIFT, index=0: go to IDLE. Drop `x_valid` and `busy`, pulse `done`, keep `x` at the last frame bit.
- IDLE with no accepted start: `x` holds its current value.
- `start`, `data` and `len` are ignored while `busy`=1; there is no queueing.
- Golden model:
  - `hist` = last two values driven on `x`, oldest first. It shifts on every clock edge, including idle hold cycles, so the model matches what the detector actually sees.
  - At each edge, if the next `x` is 0 and `hist`=2'b01, then `exp_count` increments.
  - Overlapping matches count: `01010` = 2.
  - `exp_count` wraps modulo 2^32 with no saturation.
- Reset mid-frame aborts the frame. All outputs return to reset values asynchronously, and no `done` pulse is issued.

## Timing
- A frame of `len` bits occupies exactly `len` cycles with `x_valid`=1.
  - The first bit appears in the cycle after the edge that samples `start`.
- `done` is high in cycle `len+1` relative to the first bit cycle; `busy`=0 in that same cycle.
- `start` may be asserted during the `done` cycle, giving back-to-back frames with a 1-cycle gap.
  - The held bit occupies the gap and enters `hist`.
- `exp_count` updates on the same edge that launches the completing 0, so it is aligned with that bit on `x`.
- `err` is high in the cycle after the rejected `start` edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Single frame: reset, then `start` with `len`=8, `data`=8'b0101_1010. Required:
  - `x` = 0,1,0,1,1,0,1,0 on 8 consecutive valid cycles.
  - `done` in the 9th cycle; `exp_count`=2.
- Overlap: `len`=5, `data`=5'b01010. Required: `exp_count` reaches 1 on the 3rd bit and 2 on the 5th bit.
- Hold across gap: frame `len`=2, `data`=2'b01, then `start` during `done` with `len`=1, `data`=1'b0. Required:
  - `x` = 0,1,1,0.
  - `exp_count` stays 0.
- Start while busy: assert `start` with new `data` during a `len`=6 frame. Required: the frame is unchanged and there is exactly one `done`.
- Illegal length: `start` with `len`=0, then `len`=17. Required: two `err` pulses, `busy` never rises, `x` unchanged.
- Reset mid-frame: drop `reset` on the 3rd bit of a `len`=10 frame. Required:
  - Immediately `x`=0, `busy`=0, `exp_count`=0.
  - No `done` pulse.
  - A following `start` with `len`=3, `data`=3'b010 gives `exp_count`=1.
